// File: rtl/mul_div_if.sv
// Handshake and data bundle between the pipeline and the iterative multiply/divide unit.
// The master drives operations and HI/LO moves; the slave returns status and HI/LO.
interface mul_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers. It does one
// shift-add or restoring shift-subtract step per cycle and needs 32 steps per operation.
module mul_div_unit (
  input logic   clk,
  input logic   rst,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        bzero_q, bzero_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic [31:0] a_q, a_d;
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] sum, trial;
  logic [63:0] mul_step, div_step, step, prod;
  logic [31:0] quo, rem;

  always_comb begin
    mag_a = (bus.op[0] && bus.a[31]) ? -bus.a : bus.a;
    mag_b = (bus.op[0] && bus.b[31]) ? -bus.b : bus.b;

    // Multiply: work = {partial, multiplier}; the carry-out of the add is shifted in at the top.
    sum      = {1'b0, work_q[63:32]} + {1'b0, ma_q};
    mul_step = work_q[0] ? {sum, work_q[31:1]} : {1'b0, work_q[63:1]};

    // Divide: work = {remainder, dividend/quotient}; the remainder is restored when the subtract underflows.
    trial    = work_q[63:31] - {1'b0, mb_q};
    div_step = trial[32] ? {work_q[62:0], 1'b0} : {trial[31:0], work_q[30:0], 1'b1};

    step = is_div_q ? div_step : mul_step;
    prod = neg_q ? -step : step;
    quo  = neg_q ? -step[31:0] : step[31:0];
    rem  = rneg_q ? -step[63:32] : step[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    a_d      = a_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StBusy;
          cnt_d    = 5'd0;
          is_div_d = bus.op[1];
          neg_d    = bus.op[0] & (bus.a[31] ^ bus.b[31]);
          rneg_d   = bus.op[0] & bus.a[31];
          bzero_d  = (bus.b == 32'd0);
          ma_d     = mag_a;
          mb_d     = mag_b;
          a_d      = bus.a;
          work_d   = bus.op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      StBusy: begin
        work_d = step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          if (!is_div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (bzero_q) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      a_q      <= 32'd0;
      work_q   <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      a_q      <= a_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = (state_q == StBusy);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mul_div_if mif ();

  mul_div_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} from the architectural definition of each operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = {32'd0, a} * {32'd0, b};
      2'b01: res = 64'(sa * sb);
      2'b10: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_move);
    logic [31:0] ph, pl;
    logic [63:0] exp;
    int          cycles;
    bit          held;
    @(negedge clk);
    ph  = mif.hi;
    pl  = mif.lo;
    exp = model(op, a, b);
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    if (with_move) begin
      mif.mthi  = 1'b1;
      mif.mtlo  = 1'b1;
      mif.wdata = $urandom;
    end
    tick();
    mif.start = 1'b0;
    mif.mthi  = 1'b0;
    mif.mtlo  = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
    mif.op    = 2'($urandom_range(0, 3));
    cycles = 0;
    held   = 1'b1;
    while (mif.busy && cycles < 40) begin
      if (mif.hi !== ph || mif.lo !== pl) held = 1'b0;
      if (disturb && cycles == 5) begin
        mif.start = 1'b1;
        mif.mthi  = 1'b1;
        mif.mtlo  = 1'b1;
        mif.wdata = $urandom;
      end else begin
        mif.start = 1'b0;
        mif.mthi  = 1'b0;
        mif.mtlo  = 1'b0;
      end
      tick();
      cycles++;
    end
    mif.start = 1'b0;
    mif.mthi  = 1'b0;
    mif.mtlo  = 1'b0;
    check("busy_len", 64'(cycles), 64'd32);
    check("hold_busy", {63'd0, held}, 64'd1);
    check("done_pulse", {63'd0, mif.done}, 64'd1);
    check($sformatf("result op%0d %h %h", op, a, b), {mif.hi, mif.lo}, exp);
    if (disturb) mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    check("done_end", {63'd0, mif.done}, 64'd0);
    check("idle_after", {63'd0, mif.busy}, 64'd0);
    check("result_kept", {mif.hi, mif.lo}, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    int          seen_done;
    mif.start = 1'b0;
    mif.op    = 2'b00;
    mif.a     = 32'd0;
    mif.b     = 32'd0;
    mif.mthi  = 1'b0;
    mif.mtlo  = 1'b0;
    mif.wdata = 32'd0;
    tick();
    tick();
    check("rst_hi", {32'd0, mif.hi}, 64'd0);
    check("rst_lo", {32'd0, mif.lo}, 64'd0);
    check("rst_busy", {63'd0, mif.busy}, 64'd0);
    check("rst_done", {63'd0, mif.done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b01, -32'sd3, 32'd5, 1'b0, 1'b0);
    run_op(2'b11, -32'sd7, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, -32'sd100, 32'd0, 1'b0, 1'b0);
    run_op(2'b00, 32'd6, 32'd7, 1'b1, 1'b0);
    run_op(2'b01, 32'd9, -32'sd4, 1'b0, 1'b1);

    // HI/LO moves while idle, singly and together.
    w = $urandom;
    @(negedge clk);
    mif.mthi = 1'b1; mif.wdata = w;
    tick();
    mif.mthi = 1'b0;
    check("mthi", {32'd0, mif.hi}, {32'd0, w});
    w = $urandom;
    @(negedge clk);
    mif.mtlo = 1'b1; mif.wdata = w;
    tick();
    mif.mtlo = 1'b0;
    check("mtlo", {32'd0, mif.lo}, {32'd0, w});
    w = $urandom;
    @(negedge clk);
    mif.mthi = 1'b1; mif.mtlo = 1'b1; mif.wdata = w;
    tick();
    mif.mthi = 1'b0; mif.mtlo = 1'b0;
    check("mthilo", {mif.hi, mif.lo}, {w, w});

    // Abort a divide partway through.
    @(negedge clk);
    mif.start = 1'b1; mif.op = 2'b10; mif.a = 32'd1000; mif.b = 32'd7;
    tick();
    mif.start = 1'b0;
    repeat (9) tick();
    check("abort_busy", {63'd0, mif.busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_hilo", {mif.hi, mif.lo}, 64'd0);
    check("abort_busy0", {63'd0, mif.busy}, 64'd0);
    seen_done = 0;
    repeat (40) begin
      if (mif.done) seen_done++;
      tick();
    end
    check("abort_nodone", 64'(seen_done), 64'd0);
    run_op(2'b00, 32'd2, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
